// File: rtl/radix_8_ntt_pipe_pkg.sv
// Shared constants and modular add/sub helpers for the radix-8 NTT pipeline.
// Helpers work on a fixed 32-bit container with the modulus passed in, so any
// instance with N <= 31 can use them by casting in and out.
package ntt_pkg;

  localparam int N_DEFAULT      = 17;
  localparam int Q_DEFAULT      = 65537;
  localparam int W8_DEFAULT     = 16;
  localparam int W8_INV_DEFAULT = 61441;
  localparam int LAT            = 4;
  localparam int WMAX           = 32;

  // x < 2q assumed; brings x into [0, q).
  function automatic logic [WMAX-1:0] mod_reduce_once(input logic [WMAX-1:0] x,
                                                      input logic [WMAX-1:0] q);
    return (x >= q) ? (x - q) : x;
  endfunction

  // x, y < q; sum formed one bit wider so it can never wrap.
  function automatic logic [WMAX-1:0] mod_add(input logic [WMAX-1:0] x,
                                              input logic [WMAX-1:0] y,
                                              input logic [WMAX-1:0] q);
    logic [WMAX:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[WMAX-1:0];
  endfunction

  // x, y < q; when x < y the wrapped result x + q - y is already below q.
  function automatic logic [WMAX-1:0] mod_sub(input logic [WMAX-1:0] x,
                                              input logic [WMAX-1:0] y,
                                              input logic [WMAX-1:0] q);
    return (x >= y) ? (x - y) : (x + q - y);
  endfunction

endpackage

// File: rtl/radix_8_ntt_pipe_mod_mul.sv
// Combinational modular multiplier: both operands < Q, result = a*b mod Q.
module ntt_mod_mul #(
  parameter int N = 17,
  parameter int Q = 65537
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);

  localparam logic [2*N-1:0] QW = (2*N)'(Q);

  logic [2*N-1:0] prod;

  // Full-width product then exact reduction by the constant modulus.
  always_comb begin
    prod = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};
    p_o  = N'(prod % QW);
  end

endmodule

// File: rtl/radix_8_ntt_pipe.sv
// Four-stage radix-8 DIF NTT butterfly with per-beat forward/inverse root.
// S1 reduces inputs and does layer 1, S2 applies w^1..3 and layer 2,
// S3 applies w^2 and layer 3 (reordered to natural k), S4 scales by tf_k.
//
// Handshake: a transfer happens on a rising edge when valid && ready on that
// side. The whole pipe advances together on en = !out_valid || out_ready, and
// in_ready = en, so a stalled output freezes every stage including bubbles.
module radix_8_ntt_pipe
  import ntt_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int Q      = Q_DEFAULT,
  parameter int W8     = W8_DEFAULT,
  parameter int W8_INV = W8_INV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [N-1:0] a0, a1, a2, a3, a4, a5, a6, a7,
  input  logic [N-1:0] tf0, tf1, tf2, tf3, tf4, tf5, tf6, tf7,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_inv,
  output logic [N-1:0] A0, A1, A2, A3, A4, A5, A6, A7,
  output logic         busy
);

  localparam logic [WMAX-1:0] QW = WMAX'(Q);

  function automatic logic [N-1:0] red_q(input logic [N-1:0] x);
    return N'(mod_reduce_once(WMAX'(x), QW));
  endfunction

  function automatic logic [N-1:0] add_q(input logic [N-1:0] x, input logic [N-1:0] y);
    return N'(mod_add(WMAX'(x), WMAX'(y), QW));
  endfunction

  function automatic logic [N-1:0] sub_q(input logic [N-1:0] x, input logic [N-1:0] y);
    return N'(mod_sub(WMAX'(x), WMAX'(y), QW));
  endfunction

  // Elaboration-time product used only to derive root powers.
  function automatic logic [N-1:0] cmul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    return N'(p % (2*N)'(Q));
  endfunction

  localparam logic [N-1:0] W1F = N'(W8);
  localparam logic [N-1:0] W2F = cmul(W1F, W1F);
  localparam logic [N-1:0] W3F = cmul(W2F, W1F);
  localparam logic [N-1:0] W1I = N'(W8_INV);
  localparam logic [N-1:0] W2I = cmul(W1I, W1I);
  localparam logic [N-1:0] W3I = cmul(W2I, W1I);

  logic [N-1:0] a_in  [8];
  logic [N-1:0] tf_in [8];

  assign a_in[0] = a0;  assign a_in[1] = a1;  assign a_in[2] = a2;  assign a_in[3] = a3;
  assign a_in[4] = a4;  assign a_in[5] = a5;  assign a_in[6] = a6;  assign a_in[7] = a7;
  assign tf_in[0] = tf0; assign tf_in[1] = tf1; assign tf_in[2] = tf2; assign tf_in[3] = tf3;
  assign tf_in[4] = tf4; assign tf_in[5] = tf5; assign tf_in[6] = tf6; assign tf_in[7] = tf7;

  logic         en;
  logic         s1_v_q, s2_v_q, s3_v_q, out_valid_q;
  logic         s1_inv_q, s2_inv_q, s3_inv_q, out_inv_q;
  logic [N-1:0] s1_x_q [8], s1_tf_q [8];
  logic [N-1:0] s2_x_q [8], s2_tf_q [8];
  logic [N-1:0] s3_x_q [8], s3_tf_q [8];
  logic [N-1:0] out_q  [8];

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign busy      = s1_v_q | s2_v_q | s3_v_q | out_valid_q;
  assign out_valid = out_valid_q;
  assign out_inv   = out_inv_q;
  assign A0 = out_q[0]; assign A1 = out_q[1]; assign A2 = out_q[2]; assign A3 = out_q[3];
  assign A4 = out_q[4]; assign A5 = out_q[5]; assign A6 = out_q[6]; assign A7 = out_q[7];

  // ---------------- S1: input reduction and radix-2 layer 1 ----------------
  logic [N-1:0] ar [8], tfr [8], s1_d [8];

  // Fold inputs >= Q once, then sum/difference of coefficients j and j+4.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      ar[j]  = red_q(a_in[j]);
      tfr[j] = red_q(tf_in[j]);
    end
    for (int j = 0; j < 4; j++) begin
      s1_d[j]     = add_q(ar[j], ar[j+4]);
      s1_d[j + 4] = sub_q(ar[j], ar[j+4]);
    end
  end

  // ---------------- S2: w^1..3 on lower half, radix-2 layer 2 ----------------
  logic [N-1:0] s2_w1, s2_w2, s2_w3;
  logic [N-1:0] s2_p5, s2_p6, s2_p7;
  logic [N-1:0] s2_m [8], s2_d [8];

  assign s2_w1 = s1_inv_q ? W1I : W1F;
  assign s2_w2 = s1_inv_q ? W2I : W2F;
  assign s2_w3 = s1_inv_q ? W3I : W3F;

  ntt_mod_mul #(.N(N), .Q(Q)) u_s2_mul5 (.a_i(s1_x_q[5]), .b_i(s2_w1), .p_o(s2_p5));
  ntt_mod_mul #(.N(N), .Q(Q)) u_s2_mul6 (.a_i(s1_x_q[6]), .b_i(s2_w2), .p_o(s2_p6));
  ntt_mod_mul #(.N(N), .Q(Q)) u_s2_mul7 (.a_i(s1_x_q[7]), .b_i(s2_w3), .p_o(s2_p7));

  // Twiddled lower half, then butterflies on (b, b+2) within each half.
  always_comb begin
    for (int j = 0; j < 5; j++) s2_m[j] = s1_x_q[j];
    s2_m[5] = s2_p5;
    s2_m[6] = s2_p6;
    s2_m[7] = s2_p7;
    for (int b = 0; b < 8; b += 4) begin
      s2_d[b]     = add_q(s2_m[b],     s2_m[b + 2]);
      s2_d[b + 1] = add_q(s2_m[b + 1], s2_m[b + 3]);
      s2_d[b + 2] = sub_q(s2_m[b],     s2_m[b + 2]);
      s2_d[b + 3] = sub_q(s2_m[b + 1], s2_m[b + 3]);
    end
  end

  // ---------------- S3: w^2 on odd quarters, radix-2 layer 3 ----------------
  logic [N-1:0] s3_w2, s3_p3, s3_p7;
  logic [N-1:0] s3_c [8], s3_br [8], s3_d [8];

  assign s3_w2 = s2_inv_q ? W2I : W2F;

  ntt_mod_mul #(.N(N), .Q(Q)) u_s3_mul3 (.a_i(s2_x_q[3]), .b_i(s3_w2), .p_o(s3_p3));
  ntt_mod_mul #(.N(N), .Q(Q)) u_s3_mul7 (.a_i(s2_x_q[7]), .b_i(s3_w2), .p_o(s3_p7));

  // Last butterflies give bit-reversed order; unscramble to natural k.
  always_comb begin
    for (int j = 0; j < 8; j++) s3_c[j] = s2_x_q[j];
    s3_c[3] = s3_p3;
    s3_c[7] = s3_p7;
    for (int b = 0; b < 8; b += 4) begin
      s3_br[b]     = add_q(s3_c[b],     s3_c[b + 1]);
      s3_br[b + 1] = sub_q(s3_c[b],     s3_c[b + 1]);
      s3_br[b + 2] = add_q(s3_c[b + 2], s3_c[b + 3]);
      s3_br[b + 3] = sub_q(s3_c[b + 2], s3_c[b + 3]);
    end
    s3_d[0] = s3_br[0]; s3_d[1] = s3_br[4]; s3_d[2] = s3_br[2]; s3_d[3] = s3_br[6];
    s3_d[4] = s3_br[1]; s3_d[5] = s3_br[5]; s3_d[6] = s3_br[3]; s3_d[7] = s3_br[7];
  end

  // ---------------- S4: output twiddle scaling ----------------
  logic [N-1:0] s4_d [8];

  for (genvar k = 0; k < 8; k++) begin : g_tf_mul
    ntt_mod_mul #(.N(N), .Q(Q)) u_tf_mul (.a_i(s3_x_q[k]), .b_i(s3_tf_q[k]), .p_o(s4_d[k]));
  end

  // Pipeline registers: valid bits move on en, data loads only behind a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      s3_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      s1_inv_q    <= 1'b0;
      s2_inv_q    <= 1'b0;
      s3_inv_q    <= 1'b0;
      out_inv_q   <= 1'b0;
      for (int j = 0; j < 8; j++) begin
        s1_x_q[j]  <= '0;
        s1_tf_q[j] <= '0;
        s2_x_q[j]  <= '0;
        s2_tf_q[j] <= '0;
        s3_x_q[j]  <= '0;
        s3_tf_q[j] <= '0;
        out_q[j]   <= '0;
      end
    end else if (en) begin
      s1_v_q      <= in_valid;
      s2_v_q      <= s1_v_q;
      s3_v_q      <= s2_v_q;
      out_valid_q <= s3_v_q;
      if (in_valid) begin
        s1_inv_q <= in_inv;
        for (int j = 0; j < 8; j++) begin
          s1_x_q[j]  <= s1_d[j];
          s1_tf_q[j] <= tfr[j];
        end
      end
      if (s1_v_q) begin
        s2_inv_q <= s1_inv_q;
        for (int j = 0; j < 8; j++) begin
          s2_x_q[j]  <= s2_d[j];
          s2_tf_q[j] <= s1_tf_q[j];
        end
      end
      if (s2_v_q) begin
        s3_inv_q <= s2_inv_q;
        for (int j = 0; j < 8; j++) begin
          s3_x_q[j]  <= s3_d[j];
          s3_tf_q[j] <= s2_tf_q[j];
        end
      end
      if (s3_v_q) begin
        out_inv_q <= s3_inv_q;
        for (int j = 0; j < 8; j++) out_q[j] <= s4_d[j];
      end
    end
  end

endmodule

// File: tb/tb_radix_8_ntt_pipe.sv
// Directed bench for radix_8_ntt_pipe: expected beats are queued when the
// driver sees a beat accepted; a monitor pops and compares on every output
// transfer.
module tb_radix_8_ntt_pipe;

  typedef logic [16:0] vec_t [8];

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_inv;
  logic [16:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic [16:0] tf0, tf1, tf2, tf3, tf4, tf5, tf6, tf7;
  logic        out_valid, out_ready, out_inv, busy;
  logic [16:0] A0, A1, A2, A3, A4, A5, A6, A7;

  logic [136:0] exp_q [$];
  int tests;
  int fails;

  radix_8_ntt_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .tf0(tf0), .tf1(tf1), .tf2(tf2), .tf3(tf3), .tf4(tf4), .tf5(tf5), .tf6(tf6), .tf7(tf7),
    .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7),
    .busy(busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [136:0] pack(input logic inv, input vec_t v);
    logic [136:0] r;
    r = '0;
    r[136] = inv;
    for (int k = 0; k < 8; k++) r[k*17 +: 17] = v[k];
    return r;
  endfunction

  function automatic logic [136:0] dut_beat();
    vec_t v;
    v = '{A0, A1, A2, A3, A4, A5, A6, A7};
    return pack(out_inv, v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t a, input vec_t tf, input logic inv);
    a0 = a[0]; a1 = a[1]; a2 = a[2]; a3 = a[3]; a4 = a[4]; a5 = a[5]; a6 = a[6]; a7 = a[7];
    tf0 = tf[0]; tf1 = tf[1]; tf2 = tf[2]; tf3 = tf[3];
    tf4 = tf[4]; tf5 = tf[5]; tf6 = tf[6]; tf7 = tf[7];
    in_inv = inv;
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input vec_t a, input vec_t tf, input logic inv, input vec_t ex);
    int n;
    drive(a, tf, inv);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else begin
      exp_q.push_back(pack(inv, ex));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [136:0] e, g;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        g = dut_beat();
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got %h expected none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            fails++;
            $display("FAIL beat: got %h expected %h", g, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t zero, ones, twos, imp, flat, sh1, shf, shi, v;
    int cnt;
    zero = '{0, 0, 0, 0, 0, 0, 0, 0};
    ones = '{1, 1, 1, 1, 1, 1, 1, 1};
    twos = '{2, 2, 2, 2, 2, 2, 2, 2};
    imp  = '{1, 0, 0, 0, 0, 0, 0, 0};
    flat = ones;
    sh1  = '{0, 1, 0, 0, 0, 0, 0, 0};
    shf  = '{1, 16, 256, 4096, 65536, 65521, 65281, 61441};
    shi  = '{1, 61441, 65281, 65521, 65536, 4096, 256, 16};

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(zero, zero, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_inv", out_inv, 0);
    check("reset_A0", A0, 0);
    check("reset_A7", A7, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse: all ones, single-cycle output pulse.
    send(imp, ones, 1'b0, ones);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("impulse_valid_cycles", cnt, 1);
    @(posedge clk); #1;
    drain("drain_impulse");

    // Flat input, tf 1 and 2; shifted impulse both directions; range folding.
    send(flat, ones, 1'b0, '{8, 0, 0, 0, 0, 0, 0, 0});
    send(flat, twos, 1'b0, '{16, 0, 0, 0, 0, 0, 0, 0});
    send(sh1, ones, 1'b0, shf);
    send(sh1, ones, 1'b1, shi);
    send('{65537, 0, 0, 0, 0, 0, 0, 0}, ones, 1'b0, zero);
    send('{131071, 0, 0, 0, 0, 0, 0, 0}, ones, 1'b0,
         '{65534, 65534, 65534, 65534, 65534, 65534, 65534, 65534});
    send(imp, '{65538, 65538, 65538, 65538, 65538, 65538, 65538, 65538}, 1'b0, ones);
    drain("drain_directed");

    // Eight back-to-back beats with alternating direction.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send(sh1, ones, 1'b0, shf);
      else            send(sh1, ones, 1'b1, shi);
    end
    drain("drain_stream");

    // Backpressure: 6 distinct beats, output stalled for 3 cycles mid-stream.
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          v = '{17'(k + 1), 0, 0, 0, 0, 0, 0, 0};
          send(v, ones, 1'(k % 2),
               '{17'(k + 1), 17'(k + 1), 17'(k + 1), 17'(k + 1),
                 17'(k + 1), 17'(k + 1), 17'(k + 1), 17'(k + 1)});
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          tests++;
          if (exp_q.size() == 0 || dut_beat() !== exp_q[0]) begin
            fails++;
            $display("FAIL stall_hold: got %h expected front of queue", dut_beat());
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with three beats in flight.
    send(flat, ones, 1'b0, '{8, 0, 0, 0, 0, 0, 0, 0});
    send(sh1, ones, 1'b1, shi);
    send(imp, twos, 1'b0, twos);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_A1", A1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(imp, ones, 1'b0, ones);
    drain("drain_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
